// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding data memory responder with grant/response delays
module data_mem_responder #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_DEPTH    = 1024,
  parameter int GNT_DELAY    = 0,
  parameter int RVALID_DELAY = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output int                      rd_count,
  output int                      wr_count,
  output logic                    proto_err_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(MEM_DEPTH);

  // Counter preload values; the extra cycle of each delay is spent in the state that loads it.
  localparam logic [3:0] GNT_LOAD = (GNT_DELAY > 0)    ? 4'(GNT_DELAY - 1)    : 4'd0;
  localparam logic [3:0] LAT_LOAD = (RVALID_DELAY > 1) ? 4'(RVALID_DELAY - 2) : 4'd0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GNT_WAIT = 3'd1,
    GNT      = 3'd2,
    LAT_WAIT = 3'd3,
    RESP     = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    err_set;
  logic                    capture;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [IDX_W-1:0]        word_idx;
  logic                    unused_addr_bits;

  // Storage powers up cleared and is never touched by reset.
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH] = '{default: '0};

  // Upper address bits wrap the array and the byte offset is ignored.
  assign word_idx         = data_addr_i[IDX_W+1:2];
  assign unused_addr_bits = ^{data_addr_i[ADDR_WIDTH-1:IDX_W+2], data_addr_i[1:0]};

  // The request fields are taken at the edge that ends the grant cycle.
  assign capture = (state_q == GNT);

  // State and delay counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; RESP doubles as IDLE so a held request is accepted back-to-back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (data_req_i) begin
          if (GNT_DELAY == 0) begin
            state_d = GNT;
          end else begin
            state_d = GNT_WAIT;
            cnt_d   = GNT_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      GNT_WAIT: begin
        if (!data_req_i) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          err_set = 1'b1;
        end else if (cnt_q == 4'd0) begin
          state_d = GNT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      GNT: begin
        if (RVALID_DELAY == 1) begin
          state_d = RESP;
        end else begin
          state_d = LAT_WAIT;
          cnt_d   = LAT_LOAD;
        end
      end
      LAT_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Handshake outputs decoded from the state; read data is forced to zero outside RESP.
  always_comb begin
    data_gnt_o    = (state_q == GNT);
    data_rvalid_o = (state_q == RESP);
    data_rdata_o  = (state_q == RESP) ? rdata_q : '0;
  end

  // Response data latch, transaction counters and sticky protocol error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q     <= '0;
      rd_count    <= 0;
      wr_count    <= 0;
      proto_err_o <= 1'b0;
    end else begin
      if (capture) begin
        if (data_we_i) begin
          rdata_q  <= '0;
          wr_count <= wr_count + 1;
        end else begin
          rdata_q  <= mem[word_idx];
          rd_count <= rd_count + 1;
        end
      end
      if (err_set) begin
        proto_err_o <= 1'b1;
      end
    end
  end

  // Byte-masked write commit at the end of the grant cycle.
  always_ff @(posedge clk_i) begin
    if (capture && data_we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (data_be_i[b]) begin
          mem[word_idx][b*8 +: 8] <= data_wdata_i[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

  localparam int G0 = 0;
  localparam int R0 = 1;
  localparam int G1 = 3;
  localparam int R1 = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        req   = 1'b0;
  int          sel   = 0;
  logic [15:0] addr  = '0;
  logic        we    = 1'b0;
  logic [3:0]  be    = '0;
  logic [31:0] wdata = '0;

  logic        req0, req1;
  logic        gnt0, gnt1, rv0, rv1, err0, err1;
  logic [31:0] rdata0, rdata1;
  int          rdc0, rdc1, wrc0, wrc1;

  logic        m_gnt, m_rv;
  logic [31:0] m_rdata;
  int          m_rdc, m_wrc;

  int          tests = 0;
  int          fails = 0;

  logic [31:0] ref_mem [2][1024];
  int          ref_rd [2];
  int          ref_wr [2];

  always #5 clk = ~clk;

  assign req0    = req && (sel == 0);
  assign req1    = req && (sel == 1);
  assign m_gnt   = (sel == 1) ? gnt1   : gnt0;
  assign m_rv    = (sel == 1) ? rv1    : rv0;
  assign m_rdata = (sel == 1) ? rdata1 : rdata0;
  assign m_rdc   = (sel == 1) ? rdc1   : rdc0;
  assign m_wrc   = (sel == 1) ? wrc1   : wrc0;

  data_mem_responder #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_DEPTH(1024), .GNT_DELAY(G0), .RVALID_DELAY(R0)
  ) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req0), .data_gnt_o(gnt0), .data_rvalid_o(rv0),
    .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_rdata_o(rdata0), .rd_count(rdc0), .wr_count(wrc0), .proto_err_o(err0)
  );

  data_mem_responder #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_DEPTH(1024), .GNT_DELAY(G1), .RVALID_DELAY(R1)
  ) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req1), .data_gnt_o(gnt1), .data_rvalid_o(rv1),
    .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_rdata_o(rdata1), .rd_count(rdc1), .wr_count(wrc1), .proto_err_o(err1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  function automatic int exp_gnt_lat(input int s);
    return (s == 1) ? G1 + 1 : G0 + 1;
  endfunction

  function automatic int exp_rv_lat(input int s);
    return (s == 1) ? R1 : R0;
  endfunction

  // Model update for a transaction granted on instance s; returns the expected rdata.
  function automatic logic [31:0] model_txn(input int s, input logic [15:0] a, input logic w,
                                            input logic [3:0] b, input logic [31:0] d);
    int idx;
    idx = int'(a[11:2]);
    if (w) begin
      ref_mem[s][idx] = merge(ref_mem[s][idx], d, b);
      ref_wr[s]++;
      return 32'h0;
    end
    ref_rd[s]++;
    return ref_mem[s][idx];
  endfunction

  task automatic do_txn(input int s, input logic [15:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, output logic [31:0] got);
    int k;
    logic [31:0] exp_rd;
    @(negedge clk);
    sel = s; addr = a; we = w; be = b; wdata = d; req = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!m_gnt && k < 64);
    chk("gnt_latency", k, exp_gnt_lat(s));
    exp_rd = model_txn(s, a, w, b, d);
    req = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (!m_rv) chk("rdata_zero_without_rvalid", m_rdata, 0);
    end while (!m_rv && k < 64);
    chk("rvalid_latency", k, exp_rv_lat(s));
    chk("rdata", m_rdata, exp_rd);
    got = m_rdata;
    @(negedge clk);
    chk("rvalid_single_cycle", m_rv, 0);
    chk("rdata_cleared", m_rdata, 0);
    chk("rd_count", m_rdc, ref_rd[s]);
    chk("wr_count", m_wrc, ref_wr[s]);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int          k;
    logic [31:0] exp_a;

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 1024; i++) ref_mem[s][i] = 32'h0;
      ref_rd[s] = 0;
      ref_wr[s] = 0;
    end

    // Reset values on both instances
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gnt0", gnt0, 0);   chk("rst_rv0", rv0, 0);   chk("rst_rdata0", rdata0, 0);
    chk("rst_err0", err0, 0);   chk("rst_rdc0", rdc0, 0); chk("rst_wrc0", wrc0, 0);
    chk("rst_gnt1", gnt1, 0);   chk("rst_rv1", rv1, 0);   chk("rst_rdata1", rdata1, 0);
    chk("rst_err1", err1, 0);   chk("rst_rdc1", rdc1, 0); chk("rst_wrc1", wrc1, 0);
    #14 rst_n = 1'b1;

    // Default timing write then read
    do_txn(0, 16'h0010, 1'b1, 4'hF, 32'hDEADBEEF, got);
    do_txn(0, 16'h0010, 1'b0, 4'h0, 32'h0, got);
    chk("basic_rdata", got, 32'hDEADBEEF);
    chk("basic_wr_count", wrc0, 1);
    chk("basic_rd_count", rdc0, 1);

    // Byte enables
    do_txn(0, 16'h0020, 1'b1, 4'hF, 32'h11223344, got);
    do_txn(0, 16'h0020, 1'b1, 4'h5, 32'hAABBCCDD, got);
    do_txn(0, 16'h0020, 1'b0, 4'h1, 32'h0, got);
    chk("byte_enable_rdata", got, 32'h11BB33DD);
    do_txn(0, 16'h0020, 1'b1, 4'h0, 32'hFFFFFFFF, got);
    do_txn(0, 16'h0022, 1'b0, 4'h0, 32'h0, got);
    chk("be_zero_unchanged", got, 32'h11BB33DD);

    // Address wrap and ignored byte offset
    do_txn(0, 16'h1004, 1'b1, 4'hF, 32'h00001234, got);
    do_txn(0, 16'h0004, 1'b0, 4'hF, 32'h0, got);
    chk("wrap_rdata", got, 32'h00001234);
    do_txn(0, 16'hF007, 1'b0, 4'hF, 32'h0, got);
    chk("wrap_high_rdata", got, 32'h00001234);
    do_txn(0, 16'h0FFC, 1'b0, 4'hF, 32'h0, got);
    chk("init_zero", got, 32'h0);

    // Delayed grant and response
    do_txn(1, 16'h0100, 1'b1, 4'hF, 32'h0BADF00D, got);
    chk("delayed_write_rdata", got, 32'h0);
    do_txn(1, 16'h0100, 1'b0, 4'hF, 32'h0, got);
    chk("delayed_read_rdata", got, 32'h0BADF00D);

    // Randomized traffic on a small set of words with random upper/low address bits
    for (int i = 0; i < 40; i++) begin
      int          s;
      logic [15:0] a;
      s = (i % 4 == 3) ? 1 : 0;
      a = 16'($urandom);
      a[11:2] = 10'($urandom_range(0, 7));
      do_txn(s, a, 1'($urandom), 4'($urandom), $urandom, got);
    end

    // Back-to-back: read then write with req held through RESP
    @(negedge clk);
    sel = 0; addr = 16'h0008; we = 1'b0; be = 4'hF; wdata = 32'h0; req = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!gnt0 && k < 64);
    chk("b2b_first_gnt_latency", k, 1);
    exp_a = model_txn(0, 16'h0008, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    chk("b2b_first_rvalid", rv0, 1);
    chk("b2b_first_rdata", rdata0, exp_a);
    chk("b2b_gnt_not_in_resp", gnt0, 0);
    addr = 16'h0030; we = 1'b1; wdata = 32'h5A5AA5A5;
    @(negedge clk);
    chk("b2b_second_gnt", gnt0, 1);
    chk("b2b_rvalid_low_in_gnt", rv0, 0);
    exp_a = model_txn(0, 16'h0030, 1'b1, 4'hF, 32'h5A5AA5A5);
    req = 1'b0;
    @(negedge clk);
    chk("b2b_second_rvalid", rv0, 1);
    chk("b2b_second_rdata", rdata0, exp_a);
    chk("b2b_rd_count", rdc0, ref_rd[0]);
    chk("b2b_wr_count", wrc0, ref_wr[0]);
    do_txn(0, 16'h0030, 1'b0, 4'hF, 32'h0, got);
    chk("b2b_readback", got, 32'h5A5AA5A5);

    // Reset during LAT_WAIT of a committed write
    @(negedge clk);
    sel = 1; addr = 16'h0040; we = 1'b1; be = 4'hF; wdata = 32'hCAFEF00D; req = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!gnt1 && k < 64);
    chk("rst_lat_gnt_latency", k, G1 + 1);
    exp_a = model_txn(1, 16'h0040, 1'b1, 4'hF, 32'hCAFEF00D);
    req = 1'b0;
    @(negedge clk);
    chk("rst_lat_no_rvalid_yet", rv1, 0);
    #2 rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      ref_rd[s] = 0;
      ref_wr[s] = 0;
    end
    chk("midrst_gnt1", gnt1, 0);    chk("midrst_rv1", rv1, 0);   chk("midrst_rdata1", rdata1, 0);
    chk("midrst_err1", err1, 0);    chk("midrst_rdc1", rdc1, 0); chk("midrst_wrc1", wrc1, 0);
    chk("midrst_rdc0", rdc0, 0);    chk("midrst_wrc0", wrc0, 0);
    #3 rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("no_rvalid_after_reset", rv1, 0);
    end
    do_txn(1, 16'h0040, 1'b0, 4'hF, 32'h0, got);
    chk("reset_kept_write", got, 32'hCAFEF00D);

    // Dropping req during GNT_WAIT
    @(negedge clk);
    sel = 1; addr = 16'h0080; we = 1'b0; be = 4'hF; req = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("gnt_wait_no_gnt", gnt1, 0);
    end
    req = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("dropped_req_no_gnt", gnt1, 0);
      chk("dropped_req_no_rvalid", rv1, 0);
    end
    chk("proto_err_set", err1, 1);
    chk("proto_err_other_clear", err0, 0);
    chk("dropped_req_rd_count", rdc1, ref_rd[1]);
    do_txn(1, 16'h0040, 1'b0, 4'hF, 32'h0, got);
    chk("after_err_rdata", got, 32'hCAFEF00D);
    chk("proto_err_sticky", err1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
